// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select encodings,
// the bubble encoding and the default reset PC.
package fetch_stage_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_FOR = 2'b10;
    localparam logic [1:0] PC_JT  = 2'b11;

    // Must stay equal to the NOOP opcode used by decode.
    localparam logic [15:0] DEFAULT_NOOP_INSTR = 16'h0000;
    localparam logic [15:0] DEFAULT_RESET_PC   = 16'h0000;

endpackage

// File: rtl/fetch_stage_return_addr_stack.sv
// Circular return-address stack used by fetch_stage when FETCH_RAS_EN is defined.
// Pushing past DEPTH overwrites the oldest entry; popping an empty stack is a no-op.
module return_addr_stack #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;
    // sp counts entries up to 2*DEPTH-1 so that a wrapped stack still unwinds
    // through every slot before reporting empty; it folds back to DEPTH, never to 0.
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FOLD = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] SP_MAX  = SP_W'(2 * DEPTH - 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [SP_W-1:0]  sp_r;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] wr_idx_s;

    assign top_idx_s = IDX_W'(sp_r - SP_ONE);
    assign wr_idx_s  = IDX_W'(sp_r);
    assign empty     = (sp_r == {SP_W{1'b0}});
    assign top       = mem_r[top_idx_s];

    // Stack pointer and storage update; a simultaneous push and pop replaces the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_r <= {SP_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && pop && !empty) begin
            mem_r[top_idx_s] <= push_data;
        end else if (push) begin
            mem_r[wr_idx_s] <= push_data;
            sp_r            <= (sp_r == SP_MAX) ? SP_FOLD : sp_r + SP_ONE;
        end else if (pop && !empty) begin
            sp_r <= sp_r - SP_ONE;
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC mux, IF/ID register and CALL return address.
// Define FETCH_RAS_EN to replace the single RR register with a return-address stack.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                PC_W       = 16,
    parameter int                INSTR_W    = 16,
    parameter logic [PC_W-1:0]   RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOOP_INSTR = DEFAULT_NOOP_INSTR,
    parameter int                RAS_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               killF,
    input  logic [1:0]         PCSrc,
    input  logic               PCsrcJType,
    input  logic               RRSrc,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [PC_W-1:0]    for_target,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    rr_out
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] rr_s;

    assign pc_plus1_s = pc_r + PC_ONE;
    assign imem_addr  = pc_r;
    assign rr_out     = rr_s;

    // Redirect target selection; PC_SEQ covers the never-expected killF-with-sequential case.
    always_comb begin
        target_s = pc_plus1_s;
        case (PCSrc)
            PC_SEQ:  target_s = pc_plus1_s;
            PC_BR:   target_s = branch_target;
            PC_FOR:  target_s = for_target;
            PC_JT:   target_s = PCsrcJType ? rr_s : jump_target;
            default: target_s = pc_plus1_s;
        endcase
    end

    // PC and IF/ID register: stall > kill > memory not ready > normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r           <= RESET_PC;
            if_id_instr    <= NOOP_INSTR;
            if_id_pc       <= {PC_W{1'b0}};
            if_id_pc_plus1 <= PC_ONE;
            if_id_valid    <= 1'b0;
        end else if (stall) begin
            pc_r <= pc_r;
        end else if (killF) begin
            pc_r        <= target_s;
            if_id_instr <= NOOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!imem_ready) begin
            if_id_instr <= NOOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            pc_r           <= pc_plus1_s;
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc_r;
            if_id_pc_plus1 <= pc_plus1_s;
            if_id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_RAS_EN
    logic            ras_pop_s;
    logic            ras_empty_s;
    logic [PC_W-1:0] ras_top_s;

    // A RET pops only when it actually redirects; the target is read before the pop lands.
    assign ras_pop_s = (PCSrc == PC_JT) & PCsrcJType & killF & ~stall;
    assign rr_s      = ras_empty_s ? {PC_W{1'b0}} : ras_top_s;

    return_addr_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (RRSrc & ~stall),
        .pop       (ras_pop_s),
        .push_data (if_id_pc_plus1),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );
`else
    // A non-positive depth removes return-address storage altogether.
    if (RAS_DEPTH > 0) begin : g_rr
        logic [PC_W-1:0] rr_r;

        // CALL in ID captures its own PC+1 as the return address.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rr_r <= {PC_W{1'b0}};
            end else if (RRSrc && !stall) begin
                rr_r <= if_id_pc_plus1;
            end else begin
                rr_r <= rr_r;
            end
        end

        assign rr_s = rr_r;
    end else begin : g_no_rr
        assign rr_s = {PC_W{1'b0}};
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the RAS scenario runs only when
// FETCH_RAS_EN is defined.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        killF;
    logic [1:0]  PCSrc;
    logic        PCsrcJType;
    logic        RRSrc;
    logic [15:0] branch_target;
    logic [15:0] for_target;
    logic [15:0] jump_target;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] imem_addr;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic [15:0] rr_out;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .killF          (killF),
        .PCSrc          (PCSrc),
        .PCsrcJType     (PCsrcJType),
        .RRSrc          (RRSrc),
        .branch_target  (branch_target),
        .for_target     (for_target),
        .jump_target    (jump_target),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .rr_out         (rr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word at address a is a ^ A5A5.
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; killF = 1'b0; PCSrc = PC_SEQ; PCsrcJType = 1'b0; RRSrc = 1'b0;
        imem_ready = 1'b1;
    endtask

    task automatic redirect(input logic [15:0] a);
        killF = 1'b1; PCSrc = PC_BR; branch_target = a;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        tests++;
        if (imem_addr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 ||
            if_id_pc !== 16'h0000 || if_id_pc_plus1 !== 16'h0001 || rr_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: addr=%h valid=%b instr=%h pc=%h pc1=%h rr=%h expected 0000 0 0000 0000 0001 0000",
                     imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1, rr_out);
        end
        reset = 1'b0;
        cycle();
        tests++;
        if (if_id_pc !== 16'h0000 || if_id_valid !== 1'b1 || if_id_instr !== 16'hA5A5) begin
            fails++;
            $display("FAIL first_fetch: pc=%h valid=%b instr=%h expected 0000 1 a5a5", if_id_pc, if_id_valid, if_id_instr);
        end
        killF = 1'b1; PCSrc = PC_FOR; for_target = 16'h0042;
        cycle();
        idle();
        tests++;
        if (imem_addr !== 16'h0042) begin
            fails++;
            $display("FAIL for_redirect: addr=%h expected 0042", imem_addr);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (imem_addr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_pc_plus1 !== 16'h0001) begin
            fails++;
            $display("FAIL async_reset: addr=%h valid=%b pc1=%h expected 0000 0 0001", imem_addr, if_id_valid, if_id_pc_plus1);
        end
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (if_id_pc !== 16'(i) || if_id_valid !== 1'b1 || if_id_instr !== (16'(i) ^ 16'hA5A5)) begin
                fails++;
                $display("FAIL post_reset_seq%0d: pc=%h valid=%b instr=%h expected %h 1 %h",
                         i, if_id_pc, if_id_valid, if_id_instr, 16'(i), 16'(i) ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_branch();
        redirect(16'h0010);
        killF = 1'b1; PCSrc = PC_BR; branch_target = 16'h0030;
        cycle();
        idle();
        tests++;
        if (if_id_valid !== 1'b0 || imem_addr !== 16'h0030) begin
            fails++;
            $display("FAIL branch_flush: valid=%b addr=%h expected 0 0030", if_id_valid, imem_addr);
        end
        cycle();
        tests++;
        if (if_id_pc !== 16'h0030 || if_id_valid !== 1'b1 || if_id_instr !== 16'hA595) begin
            fails++;
            $display("FAIL branch_target_fetch: pc=%h valid=%b instr=%h expected 0030 1 a595", if_id_pc, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_stall();
        redirect(16'h0004);
        cycle();
        stall = 1'b1; killF = 1'b1; PCSrc = PC_BR; branch_target = 16'h0077; RRSrc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            tests++;
            if (imem_addr !== 16'h0005 || if_id_pc !== 16'h0004 || if_id_valid !== 1'b1 || rr_out !== 16'h0000) begin
                fails++;
                $display("FAIL stall_hold%0d: addr=%h pc=%h valid=%b rr=%h expected 0005 0004 1 0000",
                         i, imem_addr, if_id_pc, if_id_valid, rr_out);
            end
        end
        stall = 1'b0; RRSrc = 1'b0;
        cycle();
        idle();
        tests++;
        if (imem_addr !== 16'h0077 || if_id_valid !== 1'b0 || if_id_pc !== 16'h0004) begin
            fails++;
            $display("FAIL stall_release: addr=%h valid=%b pc=%h expected 0077 0 0004", imem_addr, if_id_valid, if_id_pc);
        end
    endtask

    task automatic test_call_ret();
        redirect(16'h0007);
        cycle();
        RRSrc = 1'b1; killF = 1'b1; PCSrc = PC_JT; PCsrcJType = 1'b0; jump_target = 16'h0100;
        cycle();
        idle();
        tests++;
        if (rr_out !== 16'h0008 || imem_addr !== 16'h0100 || if_id_valid !== 1'b0) begin
            fails++;
            $display("FAIL call: rr=%h addr=%h valid=%b expected 0008 0100 0", rr_out, imem_addr, if_id_valid);
        end
        cycle();
        cycle();
        killF = 1'b1; PCSrc = PC_JT; PCsrcJType = 1'b1; jump_target = 16'h0BAD;
        cycle();
        idle();
        tests++;
        if (imem_addr !== 16'h0008) begin
            fails++;
            $display("FAIL ret_target: addr=%h expected 0008", imem_addr);
        end
        cycle();
        tests++;
        if (if_id_pc !== 16'h0008 || if_id_valid !== 1'b1) begin
            fails++;
            $display("FAIL ret_fetch: pc=%h valid=%b expected 0008 1", if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_imem_ready();
        redirect(16'h0020);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (imem_addr !== 16'h0020 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin
                fails++;
                $display("FAIL not_ready%0d: addr=%h valid=%b instr=%h expected 0020 0 0000", i, imem_addr, if_id_valid, if_id_instr);
            end
        end
        imem_ready = 1'b1;
        cycle();
        tests++;
        if (if_id_pc !== 16'h0020 || if_id_valid !== 1'b1 || imem_addr !== 16'h0021) begin
            fails++;
            $display("FAIL ready_resume: pc=%h valid=%b addr=%h expected 0020 1 0021", if_id_pc, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect(16'hFFFF);
        cycle();
        tests++;
        if (if_id_pc !== 16'hFFFF || if_id_pc_plus1 !== 16'h0000 || imem_addr !== 16'h0000) begin
            fails++;
            $display("FAIL pc_wrap: pc=%h pc1=%h addr=%h expected ffff 0000 0000", if_id_pc, if_id_pc_plus1, imem_addr);
        end
        killF = 1'b1; PCSrc = PC_SEQ;
        cycle();
        idle();
        tests++;
        if (imem_addr !== 16'h0001 || if_id_valid !== 1'b0) begin
            fails++;
            $display("FAIL seq_kill: addr=%h valid=%b expected 0001 0", imem_addr, if_id_valid);
        end
    endtask

`ifdef FETCH_RAS_EN
    task automatic test_ras();
        logic [15:0] exp_ret [6];
        exp_ret = '{16'h0042, 16'h0032, 16'h0022, 16'h0012, 16'h0042, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            redirect(16'(16 * i + 1));
            cycle();
            RRSrc = 1'b1; killF = 1'b1; PCSrc = PC_JT; PCsrcJType = 1'b0; jump_target = 16'h0200;
            cycle();
            idle();
            tests++;
            if (rr_out !== 16'(16 * i + 2)) begin
                fails++;
                $display("FAIL ras_push%0d: rr=%h expected %h", i, rr_out, 16'(16 * i + 2));
            end
        end
        for (int i = 0; i < 6; i++) begin
            killF = 1'b1; PCSrc = PC_JT; PCsrcJType = 1'b1;
            cycle();
            idle();
            tests++;
            if (imem_addr !== exp_ret[i]) begin
                fails++;
                $display("FAIL ras_pop%0d: addr=%h expected %h", i, imem_addr, exp_ret[i]);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        branch_target = 16'h0000; for_target = 16'h0000; jump_target = 16'h0000;
        idle();
        cycle();
        cycle();
        test_reset();
        test_branch();
        test_stall();
        test_call_ret();
        test_imem_ready();
        test_wrap();
`ifdef FETCH_RAS_EN
        test_ras();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
